// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline stage types and helpers
package pipe_pkg;

   // Stage register occupancy states
   typedef enum logic [1:0] {
      PS_EMPTY,
      PS_FULL,
      PS_SKID
   } pipe_state_t;

   // Fetch/decode boundary payload
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
   } if_id_t;

   localparam int IF_ID_W = $bits(if_id_t);

   // Number of payload entries held in a given state
   function automatic logic [1:0] state_occ(input pipe_state_t s);
      case (s)
         PS_FULL: state_occ = 2'd1;
         PS_SKID: state_occ = 2'd2;
         default: state_occ = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - valid/ready/data handshake bundle
interface pipe_skid_reg_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = IF_ID_W
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   // Producer side drives valid/data and observes ready
   modport master (output valid, output data, input ready);
   // Consumer side observes valid/data and drives ready
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter with synchronous clear
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Clear wins over increment; the count sticks at all-ones instead of wrapping
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with optional skid entry, flush and stall counter
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = IF_ID_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter bit                SKID      = 1'b1,
   parameter int                CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   pipe_skid_reg_if.slave   in_if,
   pipe_skid_reg_if.master  out_if,
   output logic [1:0]       occupancy,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] stall_cnt
);

   pipe_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_fire, out_fire;

   // With the skid entry, ready depends only on state flops; otherwise it looks through to out_ready
   assign in_if.ready  = SKID ? (state_q != PS_SKID)
                              : ((state_q == PS_EMPTY) || out_if.ready);
   assign out_if.valid = (state_q != PS_EMPTY);
   // main is forced to RESET_VAL whenever the stage empties, so it doubles as the idle output
   assign out_if.data  = main_q;
   assign occupancy    = state_occ(state_q);

   assign in_fire  = in_if.valid && in_if.ready;
   assign out_fire = out_if.valid && out_if.ready;

   // Next state and payload; in_data is only ever sampled on an accepted transfer
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = PS_EMPTY;
         main_d  = RESET_VAL;
         skid_d  = RESET_VAL;
      end else begin
         case (state_q)
            PS_EMPTY: begin
               if (in_fire) begin
                  state_d = PS_FULL;
                  main_d  = in_if.data;
               end
            end
            PS_FULL: begin
               if (in_fire && out_fire) begin
                  main_d = in_if.data;
               end else if (out_fire) begin
                  state_d = PS_EMPTY;
                  main_d  = RESET_VAL;
               end else if (in_fire && SKID) begin
                  state_d = PS_SKID;
                  skid_d  = in_if.data;
               end
            end
            PS_SKID: begin
               if (out_fire) begin
                  state_d = PS_FULL;
                  main_d  = skid_q;
                  skid_d  = RESET_VAL;
               end
            end
            default: begin
               state_d = PS_EMPTY;
               main_d  = RESET_VAL;
               skid_d  = RESET_VAL;
            end
         endcase
      end
   end

   // State and payload registers
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= PS_EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .clr   (clr_stats),
      .inc   (out_if.valid && !out_if.ready),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed table-driven bench for pipe_skid_reg
module tb_pipe_skid_reg;
   import pipe_pkg::*;

   localparam int            DW = IF_ID_W;
   localparam logic [DW-1:0] RV = {32'h0000_0013, 32'h0000_0000};

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic          nRST, flush, clr_stats;
   logic          in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic          b_in_valid, b_out_ready;
   logic [DW-1:0] b_in_data;

   logic [1:0]  a_occ, b_occ, c_occ;
   logic [15:0] a_cnt, b_cnt;
   logic [2:0]  c_cnt;

   pipe_skid_reg_if #(.DATA_W(DW)) a_in ();
   pipe_skid_reg_if #(.DATA_W(DW)) a_out ();
   pipe_skid_reg_if #(.DATA_W(DW)) b_in ();
   pipe_skid_reg_if #(.DATA_W(DW)) b_out ();
   pipe_skid_reg_if #(.DATA_W(DW)) c_in ();
   pipe_skid_reg_if #(.DATA_W(DW)) c_out ();

   assign a_in.valid  = in_valid;
   assign a_in.data   = in_data;
   assign a_out.ready = out_ready;
   assign c_in.valid  = in_valid;
   assign c_in.data   = in_data;
   assign c_out.ready = out_ready;
   assign b_in.valid  = b_in_valid;
   assign b_in.data   = b_in_data;
   assign b_out.ready = b_out_ready;

   pipe_skid_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(16)) dut_a (
      .CLK(CLK), .nRST(nRST), .flush(flush), .in_if(a_in), .out_if(a_out),
      .occupancy(a_occ), .clr_stats(clr_stats), .stall_cnt(a_cnt));

   pipe_skid_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(3)) dut_c (
      .CLK(CLK), .nRST(nRST), .flush(flush), .in_if(c_in), .out_if(c_out),
      .occupancy(c_occ), .clr_stats(clr_stats), .stall_cnt(c_cnt));

   pipe_skid_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b0), .CNT_W(16)) dut_b (
      .CLK(CLK), .nRST(nRST), .flush(flush), .in_if(b_in), .out_if(b_out),
      .occupancy(b_occ), .clr_stats(clr_stats), .stall_cnt(b_cnt));

   typedef struct {
      logic          nrst, fl, clr, iv, ordy;
      logic [DW-1:0] d;
      logic          e_valid, e_ready;
      logic [1:0]    e_occ;
      logic [DW-1:0] e_data;
      logic [15:0]   e_cnt;
      logic [2:0]    e_cnt_c;
   } vec_t;

   vec_t vt[$];
   int   tests = 0;
   int   fails = 0;

   task automatic add(input logic nrst, fl, clr, iv, ordy, input logic [DW-1:0] d,
                      input logic ev, er, input logic [1:0] eo, input logic [DW-1:0] ed,
                      input logic [15:0] ec, input logic [2:0] ecc);
      vec_t v;
      v.nrst = nrst; v.fl = fl; v.clr = clr; v.iv = iv; v.ordy = ordy; v.d = d;
      v.e_valid = ev; v.e_ready = er; v.e_occ = eo; v.e_data = ed;
      v.e_cnt = ec; v.e_cnt_c = ecc;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [DW-1:0] xd;
      logic [DW-1:0] stream_vals [3];
      xd = 'x;
      stream_vals[0] = 'h11; stream_vals[1] = 'h22; stream_vals[2] = 'h33;

      nRST = 1'b0; flush = 1'b0; clr_stats = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = xd;

      //  nrst fl clr iv or  data     valid rdy occ data    cnt cntc
      add(0, 0, 0, 1, 0, 'h55,     0, 1, 0, RV,     0, 0);
      add(0, 0, 0, 1, 0, 'h55,     0, 1, 0, RV,     0, 0);
      add(1, 0, 0, 1, 1, 'h11,     1, 1, 1, 'h11,   0, 0);
      add(1, 0, 0, 1, 1, 'h22,     1, 1, 1, 'h22,   0, 0);
      add(1, 0, 0, 1, 1, 'h33,     1, 1, 1, 'h33,   0, 0);
      add(1, 0, 0, 0, 1, xd,       0, 1, 0, RV,     0, 0);
      add(1, 0, 0, 1, 0, 'hA1,     1, 1, 1, 'hA1,   0, 0);
      add(1, 0, 0, 1, 0, 'hB2,     1, 0, 2, 'hA1,   1, 1);
      add(1, 0, 0, 1, 1, 'hEE,     1, 1, 1, 'hB2,   1, 1);
      add(1, 0, 0, 0, 1, xd,       0, 1, 0, RV,     1, 1);
      add(1, 0, 0, 1, 0, 'hC1,     1, 1, 1, 'hC1,   1, 1);
      add(1, 0, 0, 1, 0, 'hC2,     1, 0, 2, 'hC1,   2, 2);
      add(1, 1, 0, 1, 1, 'hCC,     0, 1, 0, RV,     2, 2);
      add(1, 0, 0, 0, 1, xd,       0, 1, 0, RV,     2, 2);
      add(1, 0, 1, 1, 0, 'hD1,     1, 1, 1, 'hD1,   0, 0);
      for (int k = 1; k <= 10; k++)
         add(1, 0, 0, 0, 0, xd,    1, 1, 1, 'hD1,   16'(k), (k > 7) ? 3'd7 : 3'(k));
      add(1, 0, 1, 0, 0, xd,       1, 1, 1, 'hD1,   0, 0);
      add(1, 0, 0, 0, 0, xd,       1, 1, 1, 'hD1,   1, 1);
      add(1, 0, 0, 0, 1, xd,       0, 1, 0, RV,     1, 1);

      for (int i = 0; i < vt.size(); i++) begin
         nRST = vt[i].nrst; flush = vt[i].fl; clr_stats = vt[i].clr;
         in_valid = vt[i].iv; out_ready = vt[i].ordy; in_data = vt[i].d;
         @(posedge CLK); #1;
         chk($sformatf("v%0d out_valid", i), DW'(a_out.valid), DW'(vt[i].e_valid));
         chk($sformatf("v%0d in_ready", i),  DW'(a_in.ready),  DW'(vt[i].e_ready));
         chk($sformatf("v%0d occupancy", i), DW'(a_occ),       DW'(vt[i].e_occ));
         chk($sformatf("v%0d out_data", i),  a_out.data,       vt[i].e_data);
         chk($sformatf("v%0d stall_cnt", i), DW'(a_cnt),       DW'(vt[i].e_cnt));
         chk($sformatf("v%0d stall_cnt_w3", i), DW'(c_cnt),    DW'(vt[i].e_cnt_c));
      end

      in_valid = 1'b0; out_ready = 1'b1; in_data = xd;

      chk("b idle in_ready", DW'(b_in.ready), DW'(1));
      for (int i = 0; i < 3; i++) begin
         b_in_valid = 1'b1; b_in_data = stream_vals[i]; b_out_ready = 1'b1;
         @(posedge CLK); #1;
         chk($sformatf("b stream%0d data", i), b_out.data, stream_vals[i]);
         chk($sformatf("b stream%0d occ", i),  DW'(b_occ), DW'(1));
      end
      b_in_valid = 1'b0; b_in_data = xd;
      @(posedge CLK); #1;
      chk("b drain valid", DW'(b_out.valid), DW'(0));
      chk("b drain data", b_out.data, RV);

      b_in_valid = 1'b1; b_in_data = 'h44; b_out_ready = 1'b0;
      @(posedge CLK); #1;
      chk("b fill data", b_out.data, DW'('h44));
      b_in_data = 'h55;
      #1;
      chk("b blocked in_ready", DW'(b_in.ready), DW'(0));
      @(posedge CLK); #1;
      chk("b hold data", b_out.data, DW'('h44));
      chk("b hold occ", DW'(b_occ), DW'(1));
      b_out_ready = 1'b1;
      #1;
      chk("b open in_ready", DW'(b_in.ready), DW'(1));
      @(posedge CLK); #1;
      chk("b replace data", b_out.data, DW'('h55));
      b_in_valid = 1'b0; b_in_data = xd;
      @(posedge CLK); #1;
      chk("b final valid", DW'(b_out.valid), DW'(0));
      chk("b final occ", DW'(b_occ), DW'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register that replaces fixed-field inter-stage latches such as the fetch/decode latch.
- Carries an opaque DATA_W payload with a valid/ready handshake on both sides.
- Optional one-entry skid buffer makes in_ready registered, cutting the upstream combinational ready path.
- Adds synchronous flush (bubble = RESET_VAL) and a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 64, payload width (e.g. instr 32 + npc 32).
- RESET_VAL, '0, payload value driven after reset or flush (NOP encoding).
- SKID, 1, 1 = two-entry skid with registered in_ready; 0 = single register with combinational ready.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- flush  in  1  discard all held and incoming data this cycle.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_data  out  DATA_W  payload (main register).
- occupancy  out  2  entries held: 0, 1 or 2.
- clr_stats  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating.

Behaviour:
- Reset (nRST low at a CLK edge): state EMPTY, main = skid = RESET_VAL, stall_cnt = 0.
- Reset values: out_valid = 0, occupancy = 0, in_ready = 1.
- Priority each edge: reset > flush > normal operation.
- States: EMPTY (occ 0), FULL (main valid, occ 1), SKID (main + skid valid, occ 2; exists only when SKID = 1).
- Definitions: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- SKID = 1 ready rule: in_ready = (state != SKID), decoded from state flops only; no combinational path from out_ready.
- SKID = 0 ready rule: in_ready = !out_valid || out_ready.
- EMPTY: in_fire -> FULL, main <= in_data. Otherwise hold.
- FULL, in_fire && out_fire: stay FULL, main <= in_data. Latency is 1 cycle; throughput is 1 per cycle.
- FULL, out_fire only: -> EMPTY, main <= RESET_VAL.
- FULL, in_fire only: SKID=1 -> SKID, skid <= in_data. This case cannot occur when SKID=0.
- FULL, no transfer: hold.
- SKID state: out_fire -> FULL, main <= skid, skid <= RESET_VAL. Otherwise hold. No input is accepted in this state.
- Ordering: order is strictly preserved; the skid entry is never emitted before main.
- Flush: state -> EMPTY; main and skid <= RESET_VAL. An in_fire in the same cycle is dropped. An out_fire in the same cycle counts as delivered downstream.
- Flush does not change stall_cnt.
- out_valid = (state != EMPTY). When !out_valid, out_data = RESET_VAL.
- stall_cnt increments on cycles where out_valid && !out_ready, and saturates at 2^CNT_W-1 (no wrap).
- clr_stats sets stall_cnt to 0. It beats an increment in the same cycle.
- in_data is unconstrained while !in_valid. Any X on in_data must not propagate unless it is accepted.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_t.
  - Stage payload structs for each pipeline boundary (if_id_t: instr, npc), so that DATA_W = $bits(if_id_t).
- Sub-module pipe_sat_counter (params CNT_W; ports CLK, nRST, clr, inc, count), reusable by other performance counters.

Test Plan:
- Reset/idle: hold nRST low 2 cycles with in_valid = 1 -> out_valid = 0, occupancy = 0, out_data = RESET_VAL, stall_cnt = 0, in_ready = 1.
- Streaming: out_ready = 1, push 0x11, 0x22, 0x33 on consecutive cycles -> each appears on out_data exactly 1 cycle later, back-to-back, with occupancy staying 1.
- Skid fill: in FULL with 0xA1, drop out_ready and push 0xB2 -> occupancy = 2 and in_ready = 0 next cycle.
  - Raise out_ready -> 0xA1 then 0xB2 in order, and in_ready returns to 1 one cycle after the first pop.
- Flush mid-flight: in SKID state, assert flush with in_valid = 1, in_data = 0xCC -> next cycle out_valid = 0, occupancy = 0, and 0xCC never appears.
- Stall counter: out_valid held with out_ready = 0 for 5 cycles -> stall_cnt = 5.
  - CNT_W = 3: 10 stalled cycles -> stall_cnt = 7.
  - clr_stats during a stall -> 0 next cycle.
- SKID = 0 build: same streaming test passes. With out_ready = 0 in FULL, in_ready = 0 combinationally and a second payload is never accepted.
